// File: rtl/appliance_pkg.sv
// Shared types for the appliance command arbiter: command layout, device codes, FSM states.
package appliance_pkg;

  localparam int unsigned CMD_W   = 11;
  localparam int unsigned DEV_W   = 2;
  localparam int unsigned FIELD_W = 2;
  localparam int unsigned VALUE_W = 5;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [DEV_W-1:0] {
    DEV_FRIDGE = 2'd0,
    DEV_AC     = 2'd1,
    DEV_WM     = 2'd2,
    DEV_PARK   = 2'd3
  } dev_type_e;

  // Bit layout, MSB first: dev_type[10:9], dev_num[8], field[7:6], sub[5], value[4:0]
  typedef struct packed {
    logic [DEV_W-1:0]   dev_type;
    logic               dev_num;
    logic [FIELD_W-1:0] field;
    logic               sub;
    logic [VALUE_W-1:0] value;
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_DRIVE  = 3'd2,
    ST_GUARD  = 3'd3,
    ST_REJECT = 3'd4
  } state_e;

endpackage

// File: rtl/appliance_cmd_arbiter_if.sv
// Requester handshake plus appliance control bus; master = command sources, slave = arbiter.
interface appliance_cmd_arbiter_if;
  import appliance_pkg::*;

  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  cmd_t               req0_cmd;
  cmd_t               req1_cmd;
  logic               bus_s0;
  logic               bus_s1;
  logic               bus_s2;
  logic               bus_s3;
  logic               bus_s4;
  logic               bus_s5;
  logic [VALUE_W-1:0] bus_inp;
  logic               busy;
  logic               done;
  logic               done_id;
  logic               err;

  modport master (
    output req_valid, req0_cmd, req1_cmd,
    input  req_ready, bus_s0, bus_s1, bus_s2, bus_s3, bus_s4, bus_s5, bus_inp,
           busy, done, done_id, err
  );

  modport slave (
    input  req_valid, req0_cmd, req1_cmd,
    output req_ready, bus_s0, bus_s1, bus_s2, bus_s3, bus_s4, bus_s5, bus_inp,
           busy, done, done_id, err
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin grant; last_grant starts at 1 so requester 0 wins first after reset.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] req_valid,
  output logic [1:0] grant_c,
  output logic       grant_id_c,
  output logic       fire_c
);

  logic last_grant;

  always_comb begin
    grant_c = 2'b00;
    if (enable) begin
      case (req_valid)
        2'b01:   grant_c = 2'b01;
        2'b10:   grant_c = 2'b10;
        2'b11:   grant_c = last_grant ? 2'b01 : 2'b10;
        default: grant_c = 2'b00;
      endcase
    end
    grant_id_c = grant_c[1];
    fire_c     = |(req_valid & grant_c);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)      last_grant <= 1'b1;
    else if (fire_c) last_grant <= grant_id_c;
  end

endmodule

// File: rtl/appliance_cmd_arbiter.sv
// Arbitrates two command sources onto the shared appliance bus as SETUP -> DRIVE -> GUARD,
// keeping the device-type select parked whenever the other lines may change.
module appliance_cmd_arbiter
  import appliance_pkg::*;
#(
  parameter int unsigned      HOLD_CYCLES = 2,
  parameter logic [DEV_W-1:0] PARK_CODE   = 2'b11
) (
  input logic                    clk,
  input logic                    rst_n,
  appliance_cmd_arbiter_if.slave cmd_if
);

  state_e           state, next_state;
  cmd_t             cmd_reg, cmd_next;
  logic [DEV_W-1:0] sel_q, sel_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             busy_q, busy_next;
  logic             done_q, done_next;
  logic             err_q, err_next;
  logic             done_id_q, done_id_next;

  logic             idle_c;
  logic [1:0]       grant_c;
  logic             grant_id_c;
  logic             fire_c;
  cmd_t             sel_cmd_c;

  assign idle_c    = (state == ST_IDLE);
  assign sel_cmd_c = grant_id_c ? cmd_if.req1_cmd : cmd_if.req0_cmd;

  rr_arbiter2 u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (idle_c),
    .req_valid  (cmd_if.req_valid),
    .grant_c    (grant_c),
    .grant_id_c (grant_id_c),
    .fire_c     (fire_c)
  );

  // Next-state and next-output logic; outputs are registered from the next-state view.
  always_comb begin
    next_state   = state;
    cmd_next     = cmd_reg;
    sel_next     = sel_q;
    cnt_next     = cnt;
    done_id_next = done_id_q;
    case (state)
      ST_IDLE: begin
        if (fire_c) begin
          done_id_next = grant_id_c;
          if (sel_cmd_c.dev_type == PARK_CODE) begin
            next_state = ST_REJECT;
          end else begin
            next_state = ST_SETUP;
            cmd_next   = sel_cmd_c;
          end
        end
      end
      ST_SETUP: begin
        next_state = ST_DRIVE;
        cnt_next   = CNT_W'(HOLD_CYCLES - 1);
        sel_next   = cmd_reg.dev_type;
      end
      ST_DRIVE: begin
        if (cnt == '0) begin
          next_state = ST_GUARD;
          sel_next   = PARK_CODE;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      ST_GUARD:  next_state = ST_IDLE;
      ST_REJECT: next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
    busy_next = (next_state == ST_SETUP) || (next_state == ST_DRIVE) ||
                (next_state == ST_GUARD);
    done_next = (next_state == ST_GUARD);
    err_next  = (next_state == ST_REJECT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cmd_reg   <= '0;
      sel_q     <= PARK_CODE;
      cnt       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      done_id_q <= 1'b0;
    end else begin
      state     <= next_state;
      cmd_reg   <= cmd_next;
      sel_q     <= sel_next;
      cnt       <= cnt_next;
      busy_q    <= busy_next;
      done_q    <= done_next;
      err_q     <= err_next;
      done_id_q <= done_id_next;
    end
  end

  assign cmd_if.req_ready = grant_c;
  assign cmd_if.bus_s0    = sel_q[0];
  assign cmd_if.bus_s1    = sel_q[1];
  assign cmd_if.bus_s2    = cmd_reg.dev_num;
  assign cmd_if.bus_s3    = cmd_reg.field[0];
  assign cmd_if.bus_s4    = cmd_reg.field[1];
  assign cmd_if.bus_s5    = cmd_reg.sub;
  assign cmd_if.bus_inp   = cmd_reg.value;
  assign cmd_if.busy      = busy_q;
  assign cmd_if.done      = done_q;
  assign cmd_if.done_id   = done_id_q;
  assign cmd_if.err       = err_q;

endmodule
